// File: rtl/prog_mem_loader_pkg.sv
// Shared types and helpers for the program-memory loader.
// Used by prog_mem_array and prog_mem_loader.
package prog_mem_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    RUN,
    LOAD_LO,
    LOAD_HI,
    CHECK,
    RELEASE
  } state_t;

  // Little-endian: the first byte of a pair lands in the low half of the word.
  function automatic logic [WORD_W-1:0] pack_word(input logic [7:0] lo, input logic [7:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/prog_mem_loader_if.sv
// Byte-wide valid/ready program load stream.
// master = external loader, slave = prog_mem_loader.
interface prog_mem_loader_if;

  logic       load_start;
  logic       load_valid;
  logic [7:0] load_byte;
  logic       load_last;
  logic       load_ready;

  modport master (
    output load_start,
    output load_valid,
    output load_byte,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_start,
    input  load_valid,
    input  load_byte,
    input  load_last,
    output load_ready
  );

endinterface

// File: rtl/prog_mem_array.sv
// DEPTH x 16 instruction storage: one synchronous write port,
// one combinational read port, whole-array clear on rst.
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Zero-latency read: the CPU already registered the address.
  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/prog_mem_loader.sv
// Instruction-memory responder that loads its program over a byte stream
// and holds the CPU in reset meanwhile. Optional trailing checksum byte:
// define PROG_MEM_LOADER_CHECKSUM_EN.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   mem_address,
  output logic [WORD_W-1:0]   mem_value,
  prog_mem_loader_if.slave    lif,
  output logic                cpu_rst,
  output logic [ADDR_W:0]     words_loaded,
  output logic                overflow,
  output logic                checksum_err
);

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHECK;
`else
  localparam state_t END_STATE = RELEASE;
`endif

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   words_loaded_reg;
  logic              overflow_reg;
  logic [7:0]        lo_reg;
  logic              accept;
  logic              wr_req;
  logic              wr_en;
  logic              full;
  logic [WORD_W-1:0] wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD_LO;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (lif.load_start) state_next = LOAD_LO;
      LOAD_LO: if (accept) state_next = lif.load_last ? END_STATE : LOAD_HI;
      LOAD_HI: if (accept) state_next = lif.load_last ? END_STATE : LOAD_LO;
      CHECK:   if (accept) state_next = RELEASE;
      RELEASE: state_next = RUN;
      default: state_next = LOAD_LO;
    endcase
  end

  always_comb begin
    lif.load_ready = (state_reg == LOAD_LO) || (state_reg == LOAD_HI) || (state_reg == CHECK);
    cpu_rst        = (state_reg != RUN);
    accept         = lif.load_valid && lif.load_ready;
    wr_req         = accept && ((state_reg == LOAD_HI) || ((state_reg == LOAD_LO) && lif.load_last));
    full           = (words_loaded_reg == (ADDR_W+1)'(DEPTH));
    wr_en          = wr_req && !full;
    wr_data        = (state_reg == LOAD_HI) ? pack_word(lo_reg, lif.load_byte)
                                            : pack_word(lif.load_byte, 8'h00);
  end

  // The write pointer is the word count itself; it saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_loaded_reg <= '0;
      overflow_reg     <= 1'b0;
      lo_reg           <= '0;
    end else begin
      if ((state_reg == RUN) && lif.load_start) begin
        words_loaded_reg <= '0;
        overflow_reg     <= 1'b0;
      end
      if (accept && (state_reg == LOAD_LO)) begin
        lo_reg <= lif.load_byte;
      end
      if (wr_req) begin
        if (full) begin
          overflow_reg <= 1'b1;
        end else begin
          words_loaded_reg <= words_loaded_reg + 1'b1;
        end
      end
    end
  end

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_reg;
  logic       checksum_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg          <= '0;
      checksum_err_reg <= 1'b0;
    end else begin
      if ((state_reg == RUN) && lif.load_start) begin
        sum_reg          <= '0;
        checksum_err_reg <= 1'b0;
      end
      if (accept && ((state_reg == LOAD_LO) || (state_reg == LOAD_HI))) begin
        sum_reg <= sum_reg + lif.load_byte;
      end
      if (accept && (state_reg == CHECK)) begin
        checksum_err_reg <= ((sum_reg + lif.load_byte) != 8'h00);
      end
    end
  end

  assign checksum_err = checksum_err_reg;
`else
  assign checksum_err = 1'b0;
`endif

  assign words_loaded = words_loaded_reg;
  assign overflow     = overflow_reg;

  prog_mem_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (words_loaded_reg[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_addr (mem_address),
    .rd_data (mem_value)
  );

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader (small DEPTH so overflow is reachable).
// Honours PROG_MEM_LOADER_CHECKSUM_EN the same way as the RTL.
module tb_prog_mem_loader;
  import prog_mem_pkg::*;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_value;
  logic              cpu_rst;
  logic [ADDR_W:0]   words_loaded;
  logic              overflow;
  logic              checksum_err;

  int passed = 0;
  int total  = 0;

  logic [15:0] model_mem [DEPTH];
  int          exp_words;
  logic        exp_ovf;
  logic        exp_cerr;
  logic [7:0]  cur [$];

  prog_mem_loader_if lif ();

  prog_mem_loader #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_value    (mem_value),
    .lif          (lif.slave),
    .cpu_rst      (cpu_rst),
    .words_loaded (words_loaded),
    .overflow     (overflow),
    .checksum_err (checksum_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] byte_sum();
    logic [7:0] s = 8'h00;
    foreach (cur[i]) s = s + cur[i];
    return s;
  endfunction

  // Expected result of streaming 'cur' from the spec's rules: pairs of bytes,
  // little-endian, at most DEPTH words kept, the rest counted as overflow.
  task automatic model_apply(input logic [7:0] cval);
    int nw;
    logic [7:0] hi;
    nw = (cur.size() + 1) / 2;
    for (int i = 0; i < nw && i < DEPTH; i++) begin
      hi = (2*i + 1 < cur.size()) ? cur[2*i+1] : 8'h00;
      model_mem[i] = {hi, cur[2*i]};
    end
    exp_words = (nw > DEPTH) ? DEPTH : nw;
    exp_ovf   = (nw > DEPTH);
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    exp_cerr  = ((byte_sum() + cval) != 8'h00);
`else
    exp_cerr  = (cval != cval);
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    exp_words = 0;
    exp_ovf   = 1'b0;
    exp_cerr  = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      mem_address = ADDR_W'(a);
      #1;
      chk($sformatf("%s_mem[%0d]", tag, a), mem_value, model_mem[a]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic last, input bit gap);
    bit rdy;
    int n;
    lif.load_valid = 1'b1;
    lif.load_byte  = b;
    lif.load_last  = last;
    n = 0;
    do begin
      @(negedge clk);
      rdy = lif.load_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 20);
    chk("byte_accepted", rdy, 1);
    lif.load_valid = 1'b0;
    lif.load_last  = 1'b0;
    if (gap) begin
      @(negedge clk);
      chk("ready_in_gap", lif.load_ready, 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_load();
    lif.load_start = 1'b1;
    @(posedge clk);
    #1;
    lif.load_start = 1'b0;
    chk("start_cpu_rst", cpu_rst, 1);
    chk("start_ready", lif.load_ready, 1);
    chk("start_words", words_loaded, 0);
    chk("start_ovf", overflow, 0);
    chk("start_cerr", checksum_err, 0);
  endtask

  task automatic run_load(input string tag, input bit toggle, input logic [7:0] cval);
    for (int i = 0; i < cur.size(); i++) begin
      push(cur[i], (i == cur.size() - 1), toggle && (i != cur.size() - 1));
    end
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    push(cval, 1'b0, 1'b0);
`endif
    chk({tag, "_release_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_release_ready"}, lif.load_ready, 0);
    @(posedge clk);
    #1;
    chk({tag, "_run_cpu_rst"}, cpu_rst, 0);
    chk({tag, "_run_ready"}, lif.load_ready, 0);
    model_apply(cval);
    chk({tag, "_words"}, words_loaded, exp_words);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_cerr"}, checksum_err, exp_cerr);
    check_mem(tag);
  endtask

  initial begin
    logic [7:0] cval;
    bit         tog;
    int         n;

    lif.load_start = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_byte  = 8'h00;
    lif.load_last  = 1'b0;
    mem_address    = '0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    model_clear();
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_ready", lif.load_ready, 1);
    chk("rst_words", words_loaded, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cerr", checksum_err, 0);
    check_mem("rst");

    cur = '{8'h02, 8'h0A, 8'h42, 8'h05, 8'h03, 8'h00};
    run_load("basic", 1'b0, 8'h00 - byte_sum());
    chk("basic_word0", model_mem[0], 16'h0A02);

    start_load();
    cur = '{8'h01, 8'h02, 8'h03};
    run_load("odd", 1'b0, 8'h00 - byte_sum());

    start_load();
    cur = '{8'h02, 8'h0A, 8'h42, 8'h05, 8'h03, 8'h00};
    run_load("toggle", 1'b1, 8'h00 - byte_sum());

    start_load();
    cur = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    run_load("ovf", 1'b0, 8'h00 - byte_sum());

    repeat (8) begin
      start_load();
      n = $urandom_range(1, 12);
      cur.delete();
      for (int i = 0; i < n; i++) cur.push_back(8'($urandom_range(0, 255)));
      tog  = 1'($urandom_range(0, 1));
      cval = 8'h00 - byte_sum() + 8'($urandom_range(0, 1));
      run_load("rand", tog, cval);
    end

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    start_load();
    cur = '{8'h01, 8'h02};
    run_load("csum_ok", 1'b0, 8'hFD);
    start_load();
    run_load("csum_bad", 1'b0, 8'hFE);
`endif

    // load_start mid-load is ignored; rst aborts the load and clears memory
    start_load();
    push(8'h11, 1'b0, 1'b0);
    lif.load_start = 1'b1;
    @(posedge clk);
    #1;
    lif.load_start = 1'b0;
    chk("midstart_ready", lif.load_ready, 1);
    chk("midstart_cpu_rst", cpu_rst, 1);
    push(8'h22, 1'b0, 1'b0);
    mem_address = '0;
    #1;
    chk("midstart_word0", mem_value, 16'h2211);
    chk("midstart_words", words_loaded, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    chk("midrst_cpu_rst", cpu_rst, 1);
    chk("midrst_ready", lif.load_ready, 1);
    chk("midrst_words", words_loaded, 0);
    check_mem("midrst");

    cur = '{8'hAA, 8'hBB, 8'hCC};
    run_load("after_rst", 1'b0, 8'h00 - byte_sum());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
